// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module  : id_stage_pipe
// Brief   : Registered RV32I/RV64I (+CSR, optional M) decode stage with
//           EX/MEM operand forwarding, load-use interlock and valid/ready
//           handshakes. Optional feature macro: RV_M_EN.
// Revision: 1.0
// ============================================================================
module id_stage_pipe #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst_i,
    input  logic [XLEN-1:0]   inst_addr_i,
    output logic [REG_AW-1:0] reg1_raddr_o,
    output logic [REG_AW-1:0] reg2_raddr_o,
    input  logic [XLEN-1:0]   reg1_rdata_i,
    input  logic [XLEN-1:0]   reg2_rdata_i,
    input  logic              ex_wreg_i,
    input  logic [REG_AW-1:0] ex_wd_i,
    input  logic [XLEN-1:0]   ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [REG_AW-1:0] mem_wd_reg_i,
    input  logic [XLEN-1:0]   mem_wdata_reg_i,
    input  logic              flush_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       inst_o,
    output logic [XLEN-1:0]   inst_addr_o,
    output logic [XLEN-1:0]   reg1_o_op,
    output logic [XLEN-1:0]   reg2_o_op,
    output logic              reg_we_o,
    output logic [REG_AW-1:0] reg_waddr_o,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic              illegal_o,
    output logic              stall_o
);

`ifdef RV_M_EN
    localparam logic c_M_EN = 1'b1;
`else
    localparam logic c_M_EN = 1'b0;
`endif
    localparam logic c_RV32 = (XLEN == 32);

    localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_OP       = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] c_OPC_OP32     = 7'b0111011;
    localparam logic [6:0] c_OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] c_OP1_ZERO = 2'd0;
    localparam logic [1:0] c_OP1_RS1  = 2'd1;
    localparam logic [1:0] c_OP1_UIMM = 2'd2;
    localparam logic [1:0] c_OP1_ZIMM = 2'd3;
    localparam logic [1:0] c_OP2_ZERO = 2'd0;
    localparam logic [1:0] c_OP2_RS2  = 2'd1;
    localparam logic [1:0] c_OP2_IIMM = 2'd2;
    localparam logic [1:0] c_OP2_JIMM = 2'd3;

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [REG_AW-1:0] w_rd;
    logic [XLEN-1:0]   w_imm_i;
    logic [XLEN-1:0]   w_imm_u;
    logic [XLEN-1:0]   w_imm_j;
    logic [XLEN-1:0]   w_zimm;
    logic              w_illegal;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic              w_reg_we;
    logic              w_csr_we;
    logic [1:0]        w_op1_sel;
    logic [1:0]        w_op2_sel;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;
    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;
    logic              w_capture;

    logic              r_out_valid;
    logic [31:0]       r_inst;
    logic [XLEN-1:0]   r_inst_addr;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic              r_reg_we;
    logic [REG_AW-1:0] r_reg_waddr;
    logic              r_csr_we;
    logic [CSR_AW-1:0] r_csr_waddr;
    logic              r_illegal;

    assign w_opcode = inst_i[6:0];
    assign w_funct3 = inst_i[14:12];
    assign w_funct7 = inst_i[31:25];
    assign w_rs1    = REG_AW'(inst_i[19:15]);
    assign w_rs2    = REG_AW'(inst_i[24:20]);
    assign w_rd     = REG_AW'(inst_i[11:7]);
    assign w_imm_i  = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
    assign w_imm_u  = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
    assign w_imm_j  = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12],
                       inst_i[20], inst_i[30:21], 1'b0};
    assign w_zimm   = {{(XLEN-5){1'b0}}, inst_i[19:15]};

    always_comb begin
        w_illegal = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_reg_we  = 1'b0;
        w_csr_we  = 1'b0;
        w_op1_sel = c_OP1_ZERO;
        w_op2_sel = c_OP2_ZERO;
        case (w_opcode)
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_reg_we  = 1'b1;
                w_op1_sel = c_OP1_UIMM;
            end
            c_OPC_JAL: begin
                w_reg_we  = 1'b1;
                w_op2_sel = c_OP2_JIMM;
            end
            c_OPC_JALR: begin
                w_use_rs1 = 1'b1;
                w_reg_we  = 1'b1;
                w_op1_sel = c_OP1_RS1;
                w_op2_sel = c_OP2_IIMM;
                w_illegal = (w_funct3 != 3'b000);
            end
            c_OPC_BRANCH: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_op1_sel = c_OP1_RS1;
                w_op2_sel = c_OP2_RS2;
                w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            c_OPC_LOAD: begin
                w_use_rs1 = 1'b1;
                w_reg_we  = 1'b1;
                w_op1_sel = c_OP1_RS1;
                w_op2_sel = c_OP2_IIMM;
                // LD and LWU only exist on RV64
                w_illegal = (w_funct3 == 3'b111) ||
                            (c_RV32 && ((w_funct3 == 3'b011) || (w_funct3 == 3'b110)));
            end
            c_OPC_STORE: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_op1_sel = c_OP1_RS1;
                w_op2_sel = c_OP2_RS2;
                w_illegal = (w_funct3[2] == 1'b1) || (c_RV32 && (w_funct3 == 3'b011));
            end
            c_OPC_OP_IMM: begin
                w_use_rs1 = 1'b1;
                w_reg_we  = 1'b1;
                w_op1_sel = c_OP1_RS1;
                w_op2_sel = c_OP2_IIMM;
                if (w_funct3 == 3'b001)
                    w_illegal = (w_funct7[6:1] != 6'b000000) || (c_RV32 && inst_i[25]);
                else if (w_funct3 == 3'b101)
                    w_illegal = ((w_funct7[6:1] != 6'b000000) && (w_funct7[6:1] != 6'b010000)) ||
                                (c_RV32 && inst_i[25]);
            end
            c_OPC_OP_IMM32: begin
                w_use_rs1 = 1'b1;
                w_reg_we  = 1'b1;
                w_op1_sel = c_OP1_RS1;
                w_op2_sel = c_OP2_IIMM;
                case (w_funct3)
                    3'b000:  w_illegal = c_RV32;
                    3'b001:  w_illegal = c_RV32 || (w_funct7 != 7'b0000000);
                    3'b101:  w_illegal = c_RV32 || ((w_funct7 != 7'b0000000) &&
                                                    (w_funct7 != 7'b0100000));
                    default: w_illegal = 1'b1;
                endcase
            end
            c_OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_reg_we  = 1'b1;
                w_op1_sel = c_OP1_RS1;
                w_op2_sel = c_OP2_RS2;
                if (w_funct7 == 7'b0000001)
                    w_illegal = !c_M_EN;
                else if (w_funct7 == 7'b0100000)
                    w_illegal = (w_funct3 != 3'b000) && (w_funct3 != 3'b101);
                else
                    w_illegal = (w_funct7 != 7'b0000000);
            end
            c_OPC_OP32: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_reg_we  = 1'b1;
                w_op1_sel = c_OP1_RS1;
                w_op2_sel = c_OP2_RS2;
                if (w_funct7 == 7'b0000001)
                    w_illegal = !c_M_EN || (w_funct3 inside {3'b001, 3'b010, 3'b011});
                else if (w_funct7 == 7'b0100000)
                    w_illegal = (w_funct3 != 3'b000) && (w_funct3 != 3'b101);
                else if (w_funct7 == 7'b0000000)
                    w_illegal = !(w_funct3 inside {3'b000, 3'b001, 3'b101});
                else
                    w_illegal = 1'b1;
                if (c_RV32)
                    w_illegal = 1'b1;
            end
            c_OPC_MISC_MEM: begin
                w_illegal = (w_funct3 != 3'b000) && (w_funct3 != 3'b001);
            end
            c_OPC_SYSTEM: begin
                if (w_funct3 == 3'b000) begin
                    // only ECALL / EBREAK are accepted in the privileged slot
                    w_illegal = (inst_i[19:7] != 13'd0) || (inst_i[31:21] != 11'd0);
                end else if (w_funct3 == 3'b100) begin
                    w_illegal = 1'b1;
                end else begin
                    w_reg_we  = 1'b1;
                    w_csr_we  = 1'b1;
                    w_use_rs1 = !w_funct3[2];
                    w_op1_sel = w_funct3[2] ? c_OP1_ZIMM : c_OP1_RS1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_use_rs1 = 1'b0;
            w_use_rs2 = 1'b0;
            w_reg_we  = 1'b0;
            w_csr_we  = 1'b0;
            w_op1_sel = c_OP1_ZERO;
            w_op2_sel = c_OP2_ZERO;
        end
    end

    assign reg1_raddr_o = w_use_rs1 ? w_rs1 : '0;
    assign reg2_raddr_o = w_use_rs2 ? w_rs2 : '0;

    // Forwarding priority: EX over MEM over regfile; x0 is hardwired zero
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1 != '0) begin
            if (ex_wreg_i && (ex_wd_i == w_rs1))
                w_rs1_val = ex_wdata_i;
            else if (mem_wreg_i && (mem_wd_reg_i == w_rs1))
                w_rs1_val = mem_wdata_reg_i;
            else
                w_rs1_val = reg1_rdata_i;
        end
        if (w_rs2 != '0) begin
            if (ex_wreg_i && (ex_wd_i == w_rs2))
                w_rs2_val = ex_wdata_i;
            else if (mem_wreg_i && (mem_wd_reg_i == w_rs2))
                w_rs2_val = mem_wdata_reg_i;
            else
                w_rs2_val = reg2_rdata_i;
        end
        case (w_op1_sel)
            c_OP1_RS1:  w_op1 = w_rs1_val;
            c_OP1_UIMM: w_op1 = w_imm_u;
            c_OP1_ZIMM: w_op1 = w_zimm;
            default:    w_op1 = '0;
        endcase
        case (w_op2_sel)
            c_OP2_RS2:  w_op2 = w_rs2_val;
            c_OP2_IIMM: w_op2 = w_imm_i;
            c_OP2_JIMM: w_op2 = w_imm_j;
            default:    w_op2 = '0;
        endcase
    end

    assign stall_o = ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                     ((w_use_rs1 && (ex_wd_i == w_rs1)) || (w_use_rs2 && (ex_wd_i == w_rs2)));
    assign in_ready  = (!r_out_valid || out_ready) && !stall_o && !flush_i;
    assign w_capture = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_inst      <= '0;
            r_inst_addr <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_reg_we    <= 1'b0;
            r_reg_waddr <= '0;
            r_csr_we    <= 1'b0;
            r_csr_waddr <= '0;
            r_illegal   <= 1'b0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_inst      <= inst_i;
            r_inst_addr <= inst_addr_i;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_reg_we    <= w_reg_we;
            r_reg_waddr <= w_reg_we ? w_rd : '0;
            r_csr_we    <= w_csr_we;
            r_csr_waddr <= w_csr_we ? CSR_AW'(inst_i[31:20]) : '0;
            r_illegal   <= w_illegal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign inst_o      = r_inst;
    assign inst_addr_o = r_inst_addr;
    assign reg1_o_op   = r_op1;
    assign reg2_o_op   = r_op2;
    assign reg_we_o    = r_reg_we;
    assign reg_waddr_o = r_reg_waddr;
    assign csr_we_o    = r_csr_we;
    assign csr_waddr_o = r_csr_waddr;
    assign illegal_o   = r_illegal;

endmodule
`default_nettype wire

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised, registered decode stage that replaces the purely combinational decoder between IF/ID and EX. It decodes RV32I/RV64I (plus M and CSR), reads the regfile, and forwards operands from EX/MEM. It interlocks on load-use hazards and holds results in an ID/EX output register with valid/ready handshakes on both sides.

## Interface
- `XLEN`, 64, datapath width; legal values are 32 and 64.
- `REG_AW`, 5, regfile address width.
- `CSR_AW`, 12, CSR address width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1 / `in_ready` out 1: upstream handshake.
- `inst_i` in 32; `inst_addr_i` in XLEN: instruction and its PC.
- `reg1_raddr_o`, `reg2_raddr_o` out REG_AW: combinational regfile read addresses.
- `reg1_rdata_i`, `reg2_rdata_i` in XLEN: regfile read data, same cycle.
- `ex_wreg_i` in 1, `ex_wd_i` in REG_AW, `ex_wdata_i` in XLEN, `ex_is_load_i` in 1: EX writeback info.
- `mem_wreg_i` in 1, `mem_wd_reg_i` in REG_AW, `mem_wdata_reg_i` in XLEN: MEM writeback info.
- `flush_i` in 1: kill the held and incoming instruction.
- `out_valid` out 1 / `out_ready` in 1: downstream handshake.
- `inst_o` out 32, `inst_addr_o` out XLEN, `reg1_o_op` out XLEN, `reg2_o_op` out XLEN: registered instruction, PC and operands.
- `reg_we_o` out 1, `reg_waddr_o` out REG_AW: registered regfile write control.
- `csr_we_o` out 1, `csr_waddr_o` out CSR_AW: registered CSR write control.
- `illegal_o` out 1: registered illegal-instruction flag.
- `stall_o` out 1: combinational load-use interlock indicator.

## Operation
Decode (combinational on `inst_i`):
- OP-IMM, LOAD, JALR: op1=rs1, op2=sext(I-imm).
- OP, BRANCH, STORE: op1=rs1, op2=rs2. EX re-derives the S/B immediate from `inst_o`.
- JAL: op1=0, op2=sext(J-imm).
- LUI/AUIPC: op1=sext(U-imm), op2=0.
- CSRR{W,S,C}: op1=rs1, op2=0.
- CSRR{W,S,C}I: op1=zext(zimm), op2=0.
- CSR instructions: `csr_waddr_o`=inst[31:20], `csr_we_o`=1.
- `reg_we_o`=1 with `reg_waddr_o`=rd for all instructions that write rd; otherwise 0/0.
- Unused read address outputs drive 0.

Illegal instructions:
- Cases: unknown opcode/funct3/funct7; XLEN=32 with OP-IMM-32, OP-32, LD, SD or LWU; XLEN=32 shift with inst[25]=1.
- Response: all write enables 0, both operands 0, `illegal_o`=1. The instruction is still passed downstream with `out_valid`=1.

Forwarding, per source used:
- Priority: EX (`ex_wreg_i`, `ex_wd_i`==rs) > MEM > regfile.
- rs=0 always yields 0 and never forwards.

Load-use interlock:
- Condition: `ex_is_load_i` & `ex_wreg_i` & `ex_wd_i`!=0 & `ex_wd_i` matches a used rs.
- Effect: `stall_o`=1.

Handshake:
- `in_ready` = (!`out_valid` | `out_ready`) & !`stall_o` & !`flush_i`.
- Capture occurs when `in_valid` & `in_ready`.
- Capture: output register loads the decode result and `out_valid`←1.
- Else if `out_ready`: `out_valid`←0 (bubble). Payload is unchanged.
- Else: hold all outputs stable.
- `flush_i`: `out_valid`←0 next edge; no capture that cycle. Flush wins over every other event.

## Timing
- Reset (async assert, synchronous-safe release): `out_valid`=0, `illegal_o`=0, `reg_we_o`=0, `csr_we_o`=0. All data/address outputs are 0.
- Latency: one cycle from accepted input to `out_valid`.
- Throughput: one instruction/cycle with `out_ready` held high and no hazards.
- Load-use: exactly one bubble. On the next cycle the load has moved to MEM and its data forwards from MEM.
- Stall with a full output register and `out_ready`=1: output drains and `out_valid` drops to 0.
- While `out_valid`=1 & `out_ready`=0, outputs are held bit-stable whatever the inputs do.
- Reset asserted mid-transfer discards the held instruction with no partial output.

## Configuration
- `RV_M_EN` defined: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU decode legally (funct7=0000001 in OP). For XLEN=64, the W forms in OP-32 also decode legally. Operands are rs1/rs2 with rd written.
- `RV_M_EN` undefined: those encodings raise `illegal_o`=1.

## Test plan
- XLEN=64, `addi x5,x1,-1` (0xFFF08293), x1=0x10 -> next cycle `out_valid`=1, `reg1_o_op`=0x10, `reg2_o_op`=0xFFFF_FFFF_FFFF_FFFF, `reg_waddr_o`=5.
- EX and MEM both write x3 (EX=0xAA, MEM=0xBB); `add x4,x3,x0` -> `reg1_o_op`=0xAA. With MEM only -> 0xBB. rs=x0 with `ex_wd_i`=0 -> 0.
- EX holds `ld x7` (`ex_is_load_i`=1); `add x8,x7,x2` -> `stall_o`=1, `in_ready`=0, one bubble. Next cycle with MEM forwarding x7=0x1234 -> `reg1_o_op`=0x1234.
- `out_ready`=0 for 3 cycles with `in_valid` held -> outputs unchanged and `in_ready`=0. Release -> next instruction is accepted with no loss or duplication.
- `flush_i` in the same cycle as `in_valid` -> `out_valid`=0 next cycle, nothing captured. Reset asserted mid-stream -> all outputs 0 immediately.
- `mul x1,x2,x3` (0x023100B3) without `RV_M_EN` -> `illegal_o`=1, `reg_we_o`=0. With it -> `reg_we_o`=1. XLEN=32 `ld` -> `illegal_o`=1.
